// File: rtl/csr_pkg.sv
// Shared constants for the machine-mode CSR unit.
// Holds the CSR addresses, op encodings, mstatus/mie/mip bit positions, the
// write masks, the trap cause codes and the read-modify-write helper.
package csr_pkg;

    typedef enum logic [1:0] {
        CSR_NONE = 2'b00,
        CSR_RW   = 2'b01,
        CSR_RS   = 2'b10,
        CSR_RC   = 2'b11
    } csr_op_e;

    localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADDR_MIE       = 12'h304;
    localparam logic [11:0] ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] ADDR_MEPC      = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADDR_MIP       = 12'h344;
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;

    localparam int unsigned MSTATUS_MIE_BIT  = 3;
    localparam int unsigned MSTATUS_MPIE_BIT = 7;
    localparam int unsigned MIE_MEIE_BIT     = 11;
    localparam int unsigned MIP_MEIP_BIT     = 11;

    // Masks are 64 bits wide and truncated to XLEN where used.
    localparam logic [63:0] MSTATUS_WMASK  = 64'h0000_0000_0000_0088;
    localparam logic [63:0] MSTATUS_MPP_RO = 64'h0000_0000_0000_1800;
    localparam logic [63:0] MIE_WMASK      = 64'h0000_0000_0000_0800;

    localparam int unsigned CAUSE_ILLEGAL_INSTR = 2;
    localparam int unsigned CAUSE_BREAKPOINT    = 3;
    localparam int unsigned CAUSE_ECALL_M       = 11;
    localparam int unsigned CAUSE_M_EXT_IRQ     = 11;

    // New value of a CSR for the given op, before the per-register mask.
    function automatic logic [63:0] csr_apply_op(csr_op_e op, logic [63:0] old, logic [63:0] wdata);
        case (op)
            CSR_RW:  return wdata;
            CSR_RS:  return old | wdata;
            CSR_RC:  return old & ~wdata;
            default: return old;
        endcase
    endfunction

endpackage

// File: rtl/csr_if.sv
// CSR access bus between the core (master) and the CSR unit (slave).
// csr_op/csr_addr/csr_wdata: requested access; csr_rdata/csr_illegal: same-cycle response.
interface csr_if #(parameter int unsigned XLEN = 32);
    logic [1:0]      csr_op;
    logic [11:0]     csr_addr;
    logic [XLEN-1:0] csr_wdata;
    logic [XLEN-1:0] csr_rdata;
    logic            csr_illegal;

    modport master (output csr_op, csr_addr, csr_wdata, input csr_rdata, csr_illegal);
    modport slave  (input csr_op, csr_addr, csr_wdata, output csr_rdata, csr_illegal);
endinterface

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with separate low/high word write ports.
// Ports: clk, rst (async active-high), inc (count enable), wr_lo/wr_hi with
// wdata_lo/wdata_hi (word writes), count (current value).
module csr_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata_lo,
    input  logic [31:0] wdata_hi,
    output logic [63:0] count
);

    // A write to either half suppresses the increment for that cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (wr_lo || wr_hi) begin
            if (wr_lo) count[31:0]  <= wdata_lo;
            if (wr_hi) count[63:32] <= wdata_hi;
        end else if (inc) begin
            count <= count + 64'd1;
        end
    end

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR unit: csrrw/rs/rc access, trap entry, mret, interrupt pending.
// Ports: clk, rst (async active-high), bus (csr_if slave: op/addr/wdata in,
// rdata/illegal out, combinational), trap_req/trap_cause/trap_pc (trap entry),
// mret, instr_retire, irq_ext, trap_vec (trap target), epc (mepc), irq_pending.
// Build option: CSR_COUNTERS_EN adds mcycle/minstret (and high halves on XLEN=32).
module csr_unit
    import csr_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    csr_if.slave            bus,
    input  logic            trap_req,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_pc,
    input  logic            mret,
    input  logic            instr_retire,
    input  logic            irq_ext,
    output logic [XLEN-1:0] trap_vec,
    output logic [XLEN-1:0] epc,
    output logic            irq_pending
);

    localparam logic [XLEN-1:0] MTVEC_RST = XLEN'(MTVEC_RESET);

    logic [XLEN-1:0] mstatus_q, mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mip_q;
    csr_op_e         op;
    logic [XLEN-1:0] old, wv;
    logic            impl, ro, illegal, we;

`ifdef CSR_COUNTERS_EN
    logic [63:0] cycle_cnt, instret_cnt;
`endif

    assign op = csr_op_e'(bus.csr_op);

    // Address decode and old-value read mux.
    always_comb begin
        impl = 1'b0;
        old  = '0;
        case (bus.csr_addr)
            ADDR_MSTATUS:  begin impl = 1'b1; old = mstatus_q | XLEN'(MSTATUS_MPP_RO); end
            ADDR_MIE:      begin impl = 1'b1; old = mie_q;      end
            ADDR_MTVEC:    begin impl = 1'b1; old = mtvec_q;    end
            ADDR_MSCRATCH: begin impl = 1'b1; old = mscratch_q; end
            ADDR_MEPC:     begin impl = 1'b1; old = mepc_q;     end
            ADDR_MCAUSE:   begin impl = 1'b1; old = mcause_q;   end
            ADDR_MIP:      begin impl = 1'b1; old = mip_q;      end
`ifdef CSR_COUNTERS_EN
            ADDR_MCYCLE:    begin impl = 1'b1; old = XLEN'(cycle_cnt);   end
            ADDR_MINSTRET:  begin impl = 1'b1; old = XLEN'(instret_cnt); end
            ADDR_MCYCLEH:   begin
                impl = (XLEN == 32);
                old  = impl ? XLEN'(cycle_cnt[63:32]) : '0;
            end
            ADDR_MINSTRETH: begin
                impl = (XLEN == 32);
                old  = impl ? XLEN'(instret_cnt[63:32]) : '0;
            end
`endif
            default: ;
        endcase
    end

    // A read-set/clear with zero data on a read-only CSR is a plain read.
    assign ro      = (bus.csr_addr[11:10] == 2'b11) || (bus.csr_addr == ADDR_MIP);
    assign illegal = (op != CSR_NONE) &&
                     (!impl || (ro && (op == CSR_RW || bus.csr_wdata != '0)));
    assign wv      = XLEN'(csr_apply_op(op, 64'(old), 64'(bus.csr_wdata)));
    assign we      = (op != CSR_NONE) && !illegal && !trap_req && !mret;

    assign bus.csr_rdata   = illegal ? '0 : old;
    assign bus.csr_illegal = illegal;

    // Architectural state; trap beats mret beats CSR write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mstatus_q  <= '0;
            mie_q      <= '0;
            mtvec_q    <= MTVEC_RST;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mip_q      <= '0;
        end else begin
            mip_q <= XLEN'(irq_ext) << MIP_MEIP_BIT;
            if (trap_req) begin
                mepc_q                      <= trap_pc & ~XLEN'(3);
                mcause_q                    <= trap_cause;
                mstatus_q[MSTATUS_MPIE_BIT] <= mstatus_q[MSTATUS_MIE_BIT];
                mstatus_q[MSTATUS_MIE_BIT]  <= 1'b0;
            end else if (mret) begin
                mstatus_q[MSTATUS_MIE_BIT]  <= mstatus_q[MSTATUS_MPIE_BIT];
                mstatus_q[MSTATUS_MPIE_BIT] <= 1'b1;
            end else if (we) begin
                case (bus.csr_addr)
                    ADDR_MSTATUS:  mstatus_q  <= wv & XLEN'(MSTATUS_WMASK);
                    ADDR_MIE:      mie_q      <= wv & XLEN'(MIE_WMASK);
                    // Reserved mode encodings 1x keep the current mode.
                    ADDR_MTVEC:    mtvec_q    <= {wv[XLEN-1:2], wv[1] ? mtvec_q[1:0] : wv[1:0]};
                    ADDR_MSCRATCH: mscratch_q <= wv;
                    ADDR_MEPC:     mepc_q     <= wv & ~XLEN'(3);
                    ADDR_MCAUSE:   mcause_q   <= wv;
                    default: ;
                endcase
            end
        end
    end

    // Vectored mode offsets only interrupts, by 4 * cause code.
    always_comb begin
        trap_vec = {mtvec_q[XLEN-1:2], 2'b00};
        if (mtvec_q[0] && trap_cause[XLEN-1]) begin
            trap_vec = trap_vec + {trap_cause[XLEN-3:0], 2'b00};
        end
    end

    assign epc         = mepc_q;
    assign irq_pending = mstatus_q[MSTATUS_MIE_BIT] & mie_q[MIE_MEIE_BIT] & mip_q[MIP_MEIP_BIT];

`ifdef CSR_COUNTERS_EN
    logic [63:0] wv64;
    logic [31:0] hi_data;
    logic        cyc_wr_lo, cyc_wr_hi, ret_wr_lo, ret_wr_hi;

    // On XLEN=64 the low address writes the whole counter.
    assign wv64      = 64'(wv);
    assign hi_data   = (XLEN == 32) ? wv64[31:0] : wv64[63:32];
    assign cyc_wr_lo = we && (bus.csr_addr == ADDR_MCYCLE);
    assign cyc_wr_hi = we && ((XLEN == 32) ? (bus.csr_addr == ADDR_MCYCLEH)
                                           : (bus.csr_addr == ADDR_MCYCLE));
    assign ret_wr_lo = we && (bus.csr_addr == ADDR_MINSTRET);
    assign ret_wr_hi = we && ((XLEN == 32) ? (bus.csr_addr == ADDR_MINSTRETH)
                                           : (bus.csr_addr == ADDR_MINSTRET));

    csr_counter64 u_cycle (
        .clk      (clk),
        .rst      (rst),
        .inc      (1'b1),
        .wr_lo    (cyc_wr_lo),
        .wr_hi    (cyc_wr_hi),
        .wdata_lo (wv64[31:0]),
        .wdata_hi (hi_data),
        .count    (cycle_cnt)
    );

    csr_counter64 u_instret (
        .clk      (clk),
        .rst      (rst),
        .inc      (instr_retire),
        .wr_lo    (ret_wr_lo),
        .wr_hi    (ret_wr_hi),
        .wdata_lo (wv64[31:0]),
        .wdata_hi (hi_data),
        .count    (instret_cnt)
    );
`else
    logic unused_retire;
    assign unused_retire = instr_retire;
`endif

endmodule
